// File: rtl/byteswap_control_s_axi_if.sv
// byteswap_control_s_axi_if: AXI4-Lite control channel between host and the byteswap register file
interface byteswap_control_s_axi_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/byteswap_control_s_axi.sv
// byteswap_control_s_axi: AXI4-Lite register file driving ap_ctrl_hs start/done, args and interrupt of the byteswap core
module byteswap_control_s_axi #(
   parameter int C_S_AXI_ADDR_WIDTH   = 6,
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int C_XFER_SIZE_WIDTH    = 32,
   parameter int C_M00_AXI_ADDR_WIDTH = 64
) (
   input  logic                            ap_clk,
   input  logic                            areset,
   byteswap_control_s_axi_if.slave         s_axi_control,
   output logic                            interrupt,
   output logic                            ap_start,
   input  logic                            ap_done,
   input  logic                            ap_idle,
   input  logic                            ap_ready,
   output logic [C_XFER_SIZE_WIDTH-1:0]    scalar00,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0] axi00_ptr0
);
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam logic [AW-1:0] A_CTRL = AW'(8'h00);
   localparam logic [AW-1:0] A_GIE  = AW'(8'h04);
   localparam logic [AW-1:0] A_IER  = AW'(8'h08);
   localparam logic [AW-1:0] A_ISR  = AW'(8'h0C);
   localparam logic [AW-1:0] A_SCL  = AW'(8'h10);
   localparam logic [AW-1:0] A_PLO  = AW'(8'h18);
   localparam logic [AW-1:0] A_PHI  = AW'(8'h1C);
   typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_e;
   typedef enum logic {RDIDLE, RDDATA} rstate_e;
   wstate_e wstate_q, wstate_d;
   rstate_e rstate_q, rstate_d;
   logic [AW-1:0] waddr_q, waddr_d, araddr_w;
   logic aw_hs, w_hs, ar_hs, wr_ctrl, rd_ctrl;
   logic [31:0] wmask;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic ap_start_q, ap_start_d, auto_q, auto_d, done_q, done_d, ready_q, ready_d;
   logic gie_q, gie_d, int_q, int_d;
   logic [1:0] ier_q, ier_d, isr_q, isr_d;
   logic [31:0] scalar_q, scalar_d;
   logic [63:0] ptr_q, ptr_d;
   always_ff @(posedge ap_clk) begin
      wstate_q <= areset ? WRIDLE : wstate_d;
      rstate_q <= areset ? RDIDLE : rstate_d;
   end
   always_comb begin
      wstate_d = (wstate_q == WRIDLE && s_axi_control.awvalid) ? WRDATA :
                 (wstate_q == WRDATA && s_axi_control.wvalid)  ? WRRESP :
                 (wstate_q == WRRESP && s_axi_control.bready)  ? WRIDLE : wstate_q;
      rstate_d = (rstate_q == RDIDLE && s_axi_control.arvalid) ? RDDATA :
                 (rstate_q == RDDATA && s_axi_control.rready)  ? RDIDLE : rstate_q;
   end
   always_comb begin
      s_axi_control.awready = wstate_q == WRIDLE;
      s_axi_control.wready  = wstate_q == WRDATA;
      s_axi_control.bvalid  = wstate_q == WRRESP;
      s_axi_control.bresp   = 2'b00;
      s_axi_control.arready = rstate_q == RDIDLE;
      s_axi_control.rvalid  = rstate_q == RDDATA;
      s_axi_control.rdata   = rdata_q;
      s_axi_control.rresp   = 2'b00;
   end
   // byte offset bits are dropped so every decode is a plain word compare
   assign araddr_w = s_axi_control.araddr & ~AW'(3);
   assign aw_hs    = s_axi_control.awvalid & s_axi_control.awready;
   assign w_hs     = s_axi_control.wvalid & s_axi_control.wready;
   assign ar_hs    = s_axi_control.arvalid & s_axi_control.arready;
   assign wr_ctrl  = w_hs && waddr_q == A_CTRL && s_axi_control.wstrb[0];
   assign rd_ctrl  = ar_hs && araddr_w == A_CTRL;
   assign wmask    = {{8{s_axi_control.wstrb[3]}}, {8{s_axi_control.wstrb[2]}},
                      {8{s_axi_control.wstrb[1]}}, {8{s_axi_control.wstrb[0]}}};
   always_comb begin
      waddr_d    = aw_hs ? (s_axi_control.awaddr & ~AW'(3)) : waddr_q;
      ap_start_d = (wr_ctrl && s_axi_control.wdata[0]) ? 1'b1 : (ap_ready && !auto_q) ? 1'b0 : ap_start_q;
      auto_d     = wr_ctrl ? s_axi_control.wdata[7] : auto_q;
      done_d     = ap_done ? 1'b1 : rd_ctrl ? 1'b0 : done_q;
      ready_d    = ap_ready ? 1'b1 : rd_ctrl ? 1'b0 : ready_q;
      gie_d      = (w_hs && waddr_q == A_GIE && s_axi_control.wstrb[0]) ? s_axi_control.wdata[0] : gie_q;
      ier_d      = (w_hs && waddr_q == A_IER && s_axi_control.wstrb[0]) ? s_axi_control.wdata[1:0] : ier_q;
      isr_d      = ({ap_ready, ap_done} & ier_q) |
                   ((w_hs && waddr_q == A_ISR && s_axi_control.wstrb[0]) ? isr_q ^ s_axi_control.wdata[1:0] : isr_q);
      int_d      = gie_q & |isr_q;
      scalar_d   = (w_hs && waddr_q == A_SCL) ? (s_axi_control.wdata & wmask) | (scalar_q & ~wmask) : scalar_q;
      ptr_d[31:0]  = (w_hs && waddr_q == A_PLO) ? (s_axi_control.wdata & wmask) | (ptr_q[31:0] & ~wmask) : ptr_q[31:0];
      ptr_d[63:32] = (w_hs && waddr_q == A_PHI) ? (s_axi_control.wdata & wmask) | (ptr_q[63:32] & ~wmask) : ptr_q[63:32];
      rdata_d    = araddr_w == A_CTRL ? {24'd0, auto_q, 3'd0, ready_q, ap_idle, done_q, ap_start_q} :
                   araddr_w == A_GIE  ? {31'd0, gie_q} :
                   araddr_w == A_IER  ? {30'd0, ier_q} :
                   araddr_w == A_ISR  ? {30'd0, isr_q} :
                   araddr_w == A_SCL  ? scalar_q :
                   araddr_w == A_PLO  ? ptr_q[31:0] :
                   araddr_w == A_PHI  ? ptr_q[63:32] : '0;
   end
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         waddr_q    <= '0;
         rdata_q    <= '0;
         ap_start_q <= 1'b0;
         auto_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
         gie_q      <= 1'b0;
         ier_q      <= '0;
         isr_q      <= '0;
         int_q      <= 1'b0;
      end else begin
         waddr_q    <= waddr_d;
         rdata_q    <= ar_hs ? rdata_d : rdata_q;
         ap_start_q <= ap_start_d;
         auto_q     <= auto_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
         gie_q      <= gie_d;
         ier_q      <= ier_d;
         isr_q      <= isr_d;
         int_q      <= int_d;
      end
   end
   // kernel arguments keep their value across reset
   always_ff @(posedge ap_clk) begin
      scalar_q <= scalar_d;
      ptr_q    <= ptr_d;
   end
   assign ap_start   = ap_start_q;
   assign interrupt  = int_q;
   assign scalar00   = scalar_q[C_XFER_SIZE_WIDTH-1:0];
   assign axi00_ptr0 = ptr_q[C_M00_AXI_ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_byteswap_control_s_axi.sv
// tb_byteswap_control_s_axi: directed self-checking bench for the byteswap AXI4-Lite control block
module tb_byteswap_control_s_axi;
   logic ap_clk = 1'b0;
   logic areset, ap_done, ap_idle, ap_ready;
   logic interrupt, ap_start;
   logic [31:0] scalar00;
   logic [63:0] axi00_ptr0;
   int checks = 0, failures = 0;
   byteswap_control_s_axi_if #(.ADDR_WIDTH(6)) s_axi_control ();
   byteswap_control_s_axi dut (
      .ap_clk(ap_clk), .areset(areset), .s_axi_control(s_axi_control),
      .interrupt(interrupt), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
      .ap_ready(ap_ready), .scalar00(scalar00), .axi00_ptr0(axi00_ptr0)
   );
   always #5 ap_clk = ~ap_clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF, input int bhold = 0);
      int n;
      s_axi_control.awvalid = 1'b1;
      s_axi_control.awaddr  = a;
      for (n = 0; !s_axi_control.awready && n < 20; n++) @(negedge ap_clk);
      check("aw_timeout", 64'(n < 20), 64'd1);
      @(negedge ap_clk);
      s_axi_control.awvalid = 1'b0;
      s_axi_control.wvalid  = 1'b1;
      s_axi_control.wdata   = d;
      s_axi_control.wstrb   = s;
      for (n = 0; !s_axi_control.wready && n < 20; n++) @(negedge ap_clk);
      check("w_timeout", 64'(n < 20), 64'd1);
      @(negedge ap_clk);
      s_axi_control.wvalid = 1'b0;
      repeat (bhold) begin
         check("bp_bvalid", 64'(s_axi_control.bvalid), 64'd1);
         check("bp_awready", 64'(s_axi_control.awready), 64'd0);
         @(negedge ap_clk);
      end
      s_axi_control.bready = 1'b1;
      for (n = 0; !s_axi_control.bvalid && n < 20; n++) @(negedge ap_clk);
      check("b_timeout", 64'(n < 20), 64'd1);
      @(negedge ap_clk);
      s_axi_control.bready = 1'b0;
   endtask
   task automatic axi_read(input logic [5:0] a, output logic [31:0] d, input int rhold = 0);
      int n;
      s_axi_control.arvalid = 1'b1;
      s_axi_control.araddr  = a;
      for (n = 0; !s_axi_control.arready && n < 20; n++) @(negedge ap_clk);
      check("ar_timeout", 64'(n < 20), 64'd1);
      @(negedge ap_clk);
      s_axi_control.arvalid = 1'b0;
      for (n = 0; !s_axi_control.rvalid && n < 20; n++) @(negedge ap_clk);
      check("r_timeout", 64'(n < 20), 64'd1);
      d = s_axi_control.rdata;
      repeat (rhold) begin
         @(negedge ap_clk);
         check("bp_rdata", 64'(s_axi_control.rdata), 64'(d));
      end
      s_axi_control.rready = 1'b1;
      @(negedge ap_clk);
      s_axi_control.rready = 1'b0;
   endtask
   task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      check(tag, 64'(d), 64'(exp));
   endtask
   task automatic pulse(input logic done, input logic ready);
      ap_done  = done;
      ap_ready = ready;
      @(negedge ap_clk);
      ap_done  = 1'b0;
      ap_ready = 1'b0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] d, d2;
      areset = 1'b1;
      {ap_done, ap_idle, ap_ready} = '0;
      {s_axi_control.awvalid, s_axi_control.wvalid, s_axi_control.bready} = '0;
      {s_axi_control.arvalid, s_axi_control.rready} = '0;
      s_axi_control.awaddr = '0;
      s_axi_control.araddr = '0;
      s_axi_control.wdata  = '0;
      s_axi_control.wstrb  = '0;
      repeat (3) @(negedge ap_clk);
      areset = 1'b0;
      check("rst_awready", 64'(s_axi_control.awready), 64'd1);
      check("rst_arready", 64'(s_axi_control.arready), 64'd1);
      check("rst_wready", 64'(s_axi_control.wready), 64'd0);
      check("rst_bvalid", 64'(s_axi_control.bvalid), 64'd0);
      check("rst_rvalid", 64'(s_axi_control.rvalid), 64'd0);
      check("rst_interrupt", 64'(interrupt), 64'd0);
      check("rst_ap_start", 64'(ap_start), 64'd0);
      ap_idle = 1'b1;
      rd_chk("ctrl_idle", 6'h00, 32'h4);
      ap_idle = 1'b0;
      rd_chk("rst_gie", 6'h04, 32'h0);
      rd_chk("rst_ier", 6'h08, 32'h0);
      rd_chk("rst_isr", 6'h0C, 32'h0);
      axi_write(6'h10, 32'h0000_1000);
      axi_write(6'h18, 32'h8000_0000);
      axi_write(6'h1C, 32'h0000_0001);
      check("scalar00", 64'(scalar00), 64'h1000);
      check("axi00_ptr0", axi00_ptr0, 64'h0000_0001_8000_0000);
      rd_chk("rd_scalar", 6'h10, 32'h1000);
      rd_chk("rd_ptr_lo", 6'h18, 32'h8000_0000);
      rd_chk("rd_ptr_hi", 6'h1F, 32'h1);
      axi_write(6'h24, 32'hDEAD_BEEF);
      rd_chk("rd_unmapped", 6'h24, 32'h0);
      rd_chk("rd_gap_14", 6'h14, 32'h0);
      axi_write(6'h00, 32'h1);
      check("start_set", 64'(ap_start), 64'd1);
      axi_write(6'h00, 32'h0);
      check("start_w0_keeps", 64'(ap_start), 64'd1);
      pulse(1'b1, 1'b1);
      check("start_clr", 64'(ap_start), 64'd0);
      rd_chk("ctrl_cor_1", 6'h00, 32'h0A);
      rd_chk("ctrl_cor_2", 6'h00, 32'h00);
      axi_write(6'h04, 32'h1);
      axi_write(6'h08, 32'h1);
      pulse(1'b1, 1'b0);
      @(negedge ap_clk);
      check("irq_set", 64'(interrupt), 64'd1);
      rd_chk("isr_set", 6'h0C, 32'h1);
      axi_write(6'h0C, 32'h1);
      check("irq_clr", 64'(interrupt), 64'd0);
      rd_chk("isr_clr", 6'h0C, 32'h0);
      axi_write(6'h04, 32'h0);
      pulse(1'b1, 1'b0);
      repeat (2) @(negedge ap_clk);
      check("irq_gie0", 64'(interrupt), 64'd0);
      rd_chk("isr_gie0", 6'h0C, 32'h1);
      axi_write(6'h0C, 32'h1);
      rd_chk("isr_gie0_clr", 6'h0C, 32'h0);
      rd_chk("ctrl_pre", 6'h00, 32'h02);
      s_axi_control.arvalid = 1'b1;
      s_axi_control.araddr  = 6'h00;
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
      s_axi_control.arvalid = 1'b0;
      check("coin_rvalid", 64'(s_axi_control.rvalid), 64'd1);
      d = s_axi_control.rdata;
      s_axi_control.rready = 1'b1;
      @(negedge ap_clk);
      s_axi_control.rready = 1'b0;
      check("coin_old", 64'(d), 64'h0);
      rd_chk("coin_kept", 6'h00, 32'h02);
      rd_chk("coin_clr", 6'h00, 32'h00);
      axi_write(6'h00, 32'h81);
      check("auto_start", 64'(ap_start), 64'd1);
      pulse(1'b0, 1'b1);
      check("auto_hold", 64'(ap_start), 64'd1);
      rd_chk("auto_ctrl", 6'h00, 32'h89);
      axi_write(6'h00, 32'h01);
      pulse(1'b0, 1'b1);
      check("auto_off_clr", 64'(ap_start), 64'd0);
      rd_chk("auto_off_ctrl", 6'h00, 32'h08);
      axi_write(6'h10, 32'hCAFE_F00D, 4'hF, 5);
      check("bp_scalar", 64'(scalar00), 64'hCAFE_F00D);
      axi_read(6'h10, d, 5);
      check("bp_rd", 64'(d), 64'hCAFE_F00D);
      fork
         axi_write(6'h1C, 32'h1234_5678);
         axi_read(6'h18, d2);
      join
      check("conc_rd", 64'(d2), 64'h8000_0000);
      check("conc_ptr", axi00_ptr0, 64'h1234_5678_8000_0000);
      axi_write(6'h10, 32'h1122_3344);
      axi_write(6'h10, 32'hAABB_CCDD, 4'h3);
      check("strb_scalar", 64'(scalar00), 64'h1122_CCDD);
      rd_chk("strb_rd", 6'h10, 32'h1122_CCDD);
      axi_write(6'h04, 32'h1);
      axi_write(6'h00, 32'h1);
      check("pre_rst_start", 64'(ap_start), 64'd1);
      s_axi_control.awvalid = 1'b1;
      s_axi_control.awaddr  = 6'h10;
      @(negedge ap_clk);
      s_axi_control.awvalid = 1'b0;
      check("in_wrdata", 64'(s_axi_control.wready), 64'd1);
      areset = 1'b1;
      @(negedge ap_clk);
      areset = 1'b0;
      check("mid_rst_awready", 64'(s_axi_control.awready), 64'd1);
      check("mid_rst_wready", 64'(s_axi_control.wready), 64'd0);
      check("mid_rst_bvalid", 64'(s_axi_control.bvalid), 64'd0);
      check("mid_rst_start", 64'(ap_start), 64'd0);
      check("mid_rst_scalar", 64'(scalar00), 64'h1122_CCDD);
      rd_chk("mid_rst_gie", 6'h04, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
